// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - acquisition sequencer pacing writes into the circular sample store
//
// Optional feature: define CAPSEQ_SINGLE_SHOT_EN to add the single/rearm ports.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-low reset
//   run          1 = acquire, 0 = stop (drops to IDLE)
//   mode         0 = normal trigger, 1 = auto (timeout forces trigger)
//   sample_en    one-cycle strobe, a new sample is valid
//   trigger      trigger event, any width
//   frame_done   one-cycle pulse at end of each VGA frame
//   single       (CAPSEQ_SINGLE_SHOT_EN) 1 = single-shot, HOLD waits for rearm
//   rearm        (CAPSEQ_SINGLE_SHOT_EN) pulse that leaves HOLD in single-shot
//   wren         store write enable (combinational on sample_en)
//   wraddress    store write address, advances after every write
//   rst_trig     one-cycle clear to trigger block, first PRETRIG cycle
//   display_base first store address of the captured window
//   frame_ready  one-cycle pulse in the first HOLD cycle
//   auto_trig    last completed window was forced by timeout
//   state        IDLE=0 PRETRIG=1 ARMED=2 POSTTRIG=3 HOLD=4

module capture_sequencer #(
  parameter int DEPTH_LOG2   = 10,
  parameter int SCREEN_W     = 640,
  parameter int PRE_TRIG     = 64,
  parameter int AUTO_TIMEOUT = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  mode,
  input  logic                  sample_en,
  input  logic                  trigger,
  input  logic                  frame_done,
`ifdef CAPSEQ_SINGLE_SHOT_EN
  input  logic                  single,
  input  logic                  rearm,
`endif
  output logic                  wren,
  output logic [DEPTH_LOG2-1:0] wraddress,
  output logic                  rst_trig,
  output logic [DEPTH_LOG2-1:0] display_base,
  output logic                  frame_ready,
  output logic                  auto_trig,
  output logic [2:0]            state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRETRIG  = 3'd1,
    S_ARMED    = 3'd2,
    S_POSTTRIG = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  localparam int POST_N  = SCREEN_W - PRE_TRIG - 1;
  localparam bit NO_POST = (POST_N == 0);
  localparam int CNT_W   = $clog2(SCREEN_W + 1);
  localparam int TO_W    = $clog2(AUTO_TIMEOUT + 1);

  state_t                cur, nxt;
  logic [CNT_W-1:0]      pre_cnt, post_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic                  pending;
  logic                  forced_win;
  logic [DEPTH_LOG2-1:0] trig_addr;

  logic capturing, trig_hit, forced, take;
  logic pre_last, post_last, hold_exit;
  logic enter_pretrig, enter_hold;
  logic win_forced_now;
  logic [DEPTH_LOG2-1:0] trig_now;

  assign capturing = (cur == S_PRETRIG) || (cur == S_ARMED) || (cur == S_POSTTRIG);
  // Gated by run and rst so a stop or reset never leaks a write in its own cycle.
  assign wren      = sample_en && run && rst && capturing;

  // A latched trigger or one coincident with the strobe makes this write the trigger sample.
  assign trig_hit  = (cur == S_ARMED) && wren && (pending || trigger);
  assign forced    = (cur == S_ARMED) && wren && !(pending || trigger) && mode &&
                     (to_cnt >= TO_W'(AUTO_TIMEOUT - 1));
  assign take      = trig_hit || forced;
  assign pre_last  = (cur == S_PRETRIG) && wren && (pre_cnt == CNT_W'(PRE_TRIG - 1));
  assign post_last = (cur == S_POSTTRIG) && wren && (post_cnt == CNT_W'(POST_N - 1));

  // frame_ready is high only in the HOLD entry cycle, so it masks a frame_done
  // that arrives in that same cycle.
`ifdef CAPSEQ_SINGLE_SHOT_EN
  assign hold_exit = (cur == S_HOLD) && (single ? rearm : (frame_done && !frame_ready));
`else
  assign hold_exit = (cur == S_HOLD) && frame_done && !frame_ready;
`endif

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:     if (run) nxt = S_PRETRIG;
      S_PRETRIG:  if (pre_last) nxt = S_ARMED;
      S_ARMED:    if (take) nxt = NO_POST ? S_HOLD : S_POSTTRIG;
      S_POSTTRIG: if (post_last) nxt = S_HOLD;
      S_HOLD:     if (hold_exit) nxt = S_PRETRIG;
      default:    nxt = S_IDLE;
    endcase
    if (!run) nxt = S_IDLE;
  end

  assign enter_pretrig  = (nxt == S_PRETRIG) && (cur != S_PRETRIG);
  assign enter_hold     = (nxt == S_HOLD) && (cur != S_HOLD);
  // When there is no post-trigger phase the trigger and HOLD entry share a cycle.
  assign trig_now       = take ? wraddress : trig_addr;
  assign win_forced_now = take ? forced : forced_win;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur          <= S_IDLE;
      wraddress    <= '0;
      display_base <= '0;
      rst_trig     <= 1'b0;
      frame_ready  <= 1'b0;
      auto_trig    <= 1'b0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      to_cnt       <= '0;
      pending      <= 1'b0;
      forced_win   <= 1'b0;
      trig_addr    <= '0;
    end else begin
      cur         <= nxt;
      rst_trig    <= enter_pretrig;
      frame_ready <= enter_hold;

      if (wren) wraddress <= wraddress + 1'b1;

      // Phase counters sit at zero outside their own state, so entry clears them.
      if (cur != S_PRETRIG)  pre_cnt <= '0;
      else if (wren)         pre_cnt <= pre_cnt + 1'b1;

      if (cur != S_POSTTRIG) post_cnt <= '0;
      else if (wren)         post_cnt <= post_cnt + 1'b1;

      // Saturates so normal mode can sit in ARMED indefinitely.
      if (cur != S_ARMED) to_cnt <= '0;
      else if (wren && (to_cnt < TO_W'(AUTO_TIMEOUT))) to_cnt <= to_cnt + 1'b1;

      if (cur != S_ARMED) pending <= 1'b0;
      else if (take)      pending <= 1'b0;
      else if (trigger)   pending <= 1'b1;

      if (take) begin
        trig_addr  <= wraddress;
        forced_win <= forced;
      end

      if (forced) auto_trig <= 1'b1;
      else if (enter_hold && !win_forced_now) auto_trig <= 1'b0;

      if (enter_hold) display_base <= trig_now - DEPTH_LOG2'(PRE_TRIG);
    end
  end

  assign state = cur;

endmodule
